// File: rtl/game_pkg.sv
// Shared types and constants for the squash/tennis game blocks.
package game_pkg;

  localparam logic [1:0] DIR_IDLE  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;

  localparam int LIGHT_RIGHT_END = 0;

  // Wide enough for the slowest divided clock's 26-bit toggle value.
  localparam int CNT_W = 26;

  typedef enum logic [1:0] {
    IDLE,
    REACT,
    HIT,
    CLEAR
  } opp_state_t;

  // Miss threshold out of 256; values >= 256 mean a certain miss.
  function automatic logic [8:0] miss_threshold(input logic [8:0] base,
                                                input logic [2:0] hitnum);
    return base + {3'b000, hitnum, 3'b000};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1; free-running, reloads seed on reset.
module lfsr16 (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] value_q, value_d;

  always_comb begin
    value_d = {1'b0, value_q[15:1]} ^ (value_q[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge clock) begin
    if (reset) value_q <= seed;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/cpu_opponent.sv
// Right-side CPU player: reacts to an arriving ball after a fixed delay and
// either holds rightdirection (hit) or pulses missed, with rally-scaled odds.
module cpu_opponent
  import game_pkg::*;
#(
  parameter int          REACT_CYCLES = 5_000_000,
  parameter int          HOLD_MAX     = 67_108_863,
  parameter int          MISS_BASE    = 16,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] light,
  input  logic [1:0]  direction,
  input  logic [2:0]  hitnum,
  output logic        rightdirection,
  output logic        missed,
  output logic        busy
);

  localparam logic [CNT_W-1:0] REACT_LOAD = CNT_W'(REACT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_MAX - 1);
  localparam logic [8:0]       BASE_THR   = 9'(MISS_BASE);

  opp_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             miss_q, miss_d;
  logic             rd_q, missed_q, busy_q;
  logic             missed_d;

  logic [15:0] lfsr_val;
  logic [7:0]  lfsr_hi_unused;
  logic        on_right, miss_now;

  lfsr16 u_lfsr (
    .clock (clock),
    .reset (reset),
    .seed  (LFSR_SEED),
    .value (lfsr_val)
  );

  assign lfsr_hi_unused = lfsr_val[15:8];
  assign on_right = light[LIGHT_RIGHT_END] && (direction == DIR_RIGHT);
  assign miss_now = {1'b0, lfsr_val[7:0]} < miss_threshold(BASE_THR, hitnum);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    miss_d   = miss_q;
    missed_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (on_right) begin
            state_d = REACT;
            cnt_d   = REACT_LOAD;
            miss_d  = miss_now;
          end
        end
        REACT: begin
          // Ball leaving before the delay expires beats the decision.
          if (!on_right) begin
            state_d = IDLE;
          end else if (cnt_q == '0) begin
            if (miss_q) begin
              state_d  = CLEAR;
              missed_d = 1'b1;
            end else begin
              state_d = HIT;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        HIT: begin
          if (direction == DIR_LEFT || !light[LIGHT_RIGHT_END] || cnt_q == HOLD_LAST)
            state_d = CLEAR;
          else
            cnt_d = cnt_q + 1'b1;
        end
        CLEAR: begin
          // Hold off until this arrival is over so it cannot re-trigger.
          if (!on_right) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      miss_q   <= 1'b0;
      rd_q     <= 1'b0;
      missed_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      miss_q   <= miss_d;
      rd_q     <= (state_d == HIT);
      missed_q <= missed_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign rightdirection = rd_q;
  assign missed         = missed_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_cpu_opponent.sv
// Scoreboard bench for cpu_opponent: two instances (MISS_BASE 0 and 200) share stimulus.
module tb_cpu_opponent;
  import game_pkg::*;

  localparam int          RC   = 4;
  localparam int          HM   = 10;
  localparam logic [15:0] SEED = 16'hAC21;   // low byte 0x21 = 33 < 56

  logic        clock = 1'b0;
  logic        reset, enable;
  logic [15:0] light;
  logic [1:0]  direction;
  logic [2:0]  hitnum;
  logic [1:0]  rd, missed, busy;

  cpu_opponent #(.REACT_CYCLES(RC), .HOLD_MAX(HM), .MISS_BASE(0), .LFSR_SEED(SEED)) u_dut0 (
    .clock(clock), .reset(reset), .enable(enable), .light(light), .direction(direction),
    .hitnum(hitnum), .rightdirection(rd[0]), .missed(missed[0]), .busy(busy[0]));

  cpu_opponent #(.REACT_CYCLES(RC), .HOLD_MAX(HM), .MISS_BASE(200), .LFSR_SEED(SEED)) u_dut1 (
    .clock(clock), .reset(reset), .enable(enable), .light(light), .direction(direction),
    .hitnum(hitnum), .rightdirection(rd[1]), .missed(missed[1]), .busy(busy[1]));

  always #5 clock = ~clock;

  typedef struct packed {logic rd; logic missed; logic busy;} exp_t;
  exp_t q0[$], q1[$];

  // Reference model: cycles left before deciding, cycles already held, waiting flag.
  int          react_left[2] = '{-1, -1};
  int          hold_cnt[2]   = '{-1, -1};
  bit          waiting[2]    = '{0, 0};
  bit          miss_pend[2]  = '{0, 0};
  int          mbase[2]      = '{0, 200};
  logic [15:0] lfsr_m        = SEED;

  task automatic model_step(input int k, input logic [15:0] lv, output exp_t e);
    bit on_right;
    on_right = light[0] && direction == DIR_RIGHT;
    e.missed = 1'b0;
    if (reset || !enable) begin
      react_left[k] = -1; hold_cnt[k] = -1; waiting[k] = 0;
      if (reset) miss_pend[k] = 0;
    end else if (react_left[k] >= 0) begin
      if (!on_right) react_left[k] = -1;
      else if (react_left[k] == 0) begin
        react_left[k] = -1;
        if (miss_pend[k]) begin waiting[k] = 1; e.missed = 1'b1; end
        else hold_cnt[k] = 0;
      end else react_left[k]--;
    end else if (hold_cnt[k] >= 0) begin
      if (direction == DIR_LEFT || !light[0] || hold_cnt[k] == HM - 1) begin
        hold_cnt[k] = -1; waiting[k] = 1;
      end else hold_cnt[k]++;
    end else if (waiting[k]) begin
      if (!on_right) waiting[k] = 0;
    end else if (on_right) begin
      react_left[k] = RC - 1;
      miss_pend[k]  = int'(lv[7:0]) < mbase[k] + 8 * int'(hitnum);
    end
    e.rd   = hold_cnt[k] >= 0;
    e.busy = react_left[k] >= 0 || hold_cnt[k] >= 0 || waiting[k];
  endtask

  always @(posedge clock) begin
    exp_t e0, e1;
    model_step(0, lfsr_m, e0);
    model_step(1, lfsr_m, e1);
    q0.push_back(e0);
    q1.push_back(e1);
    if (reset) lfsr_m = SEED;
    else       lfsr_m = {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
  end

  // Directed checks requested by the stimulus process, executed by the monitor.
  string dq_name[$];
  int    dq_act[$], dq_exp[$];
  int    total = 0, bad = 0;
  int    rd_hi0 = 0, miss_cnt0 = 0;

  task automatic cmp_bit(input string name, input int k, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d t=%0t got=%b want=%b", name, k, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      cmp_bit("rightdirection", 0, rd[0], e.rd);
      cmp_bit("missed", 0, missed[0], e.missed);
      cmp_bit("busy", 0, busy[0], e.busy);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      cmp_bit("rightdirection", 1, rd[1], e.rd);
      cmp_bit("missed", 1, missed[1], e.missed);
      cmp_bit("busy", 1, busy[1], e.busy);
    end
    if (rd[0] === 1'b1)     rd_hi0++;
    if (missed[0] === 1'b1) miss_cnt0++;
    while (dq_name.size() > 0) begin
      string n; int a, x;
      n = dq_name.pop_front(); a = dq_act.pop_front(); x = dq_exp.pop_front();
      total++;
      if (a != x) begin
        bad++;
        $display("FAIL %s got=%0d want=%0d", n, a, x);
      end
    end
  end

  task automatic req(input string n, input int a, input int x);
    dq_name.push_back(n); dq_act.push_back(a); dq_exp.push_back(x);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [15:0] l, input logic [1:0] d);
    light = l; direction = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int b_rd, b_ms;
    reset = 1'b1; enable = 1'b1; hitnum = 3'd0; drive(16'h0000, DIR_IDLE);
    cyc(2);

    // Forced miss on the first post-reset edge; ball stays put afterwards.
    reset = 1'b0; hitnum = 3'd7; drive(16'h0001, DIR_RIGHT);
    b_rd = rd_hi0; b_ms = miss_cnt0;
    cyc(15);
    req("miss_once", miss_cnt0 - b_ms, 1);
    req("miss_no_rd", rd_hi0 - b_rd, 0);
    drive(16'h0002, DIR_LEFT); cyc(3);

    // Forced hit, ball turned around at cycle 7.
    hitnum = 3'd0; drive(16'h0001, DIR_RIGHT);
    b_rd = rd_hi0;
    cyc(7);
    direction = DIR_LEFT;
    cyc(4);
    req("hit_len", rd_hi0 - b_rd, 3);
    drive(16'h0002, DIR_LEFT); cyc(3);
    drive(16'h0000, DIR_IDLE); cyc(2);

    // Hold timeout.
    drive(16'h0001, DIR_RIGHT);
    b_rd = rd_hi0;
    cyc(25);
    req("hold_len", rd_hi0 - b_rd, HM);
    drive(16'h0002, DIR_LEFT); cyc(2);
    drive(16'h0000, DIR_IDLE); cyc(2);

    // Abort during REACT.
    drive(16'h0001, DIR_RIGHT);
    b_rd = rd_hi0; b_ms = miss_cnt0;
    cyc(2);
    light = 16'h0002;
    cyc(8);
    req("abort_rd", rd_hi0 - b_rd, 0);
    req("abort_miss", miss_cnt0 - b_ms, 0);
    drive(16'h0000, DIR_IDLE); cyc(2);

    // Reset during HIT, then a fresh arrival.
    drive(16'h0001, DIR_RIGHT); cyc(7);
    reset = 1'b1; cyc(1);
    reset = 1'b0; cyc(12);
    drive(16'h0000, DIR_IDLE); cyc(2);

    // Enable dropped during HIT.
    drive(16'h0001, DIR_RIGHT); cyc(7);
    enable = 1'b0; cyc(2);
    enable = 1'b1; cyc(12);
    drive(16'h0000, DIR_IDLE); cyc(2);

    // Random traffic.
    repeat (400) begin
      if ($urandom_range(0, 7) == 0) begin
        light     = ($urandom_range(0, 2) == 0) ? (16'h0001 << $urandom_range(1, 15)) : 16'h0001;
        direction = 2'($urandom_range(0, 2));
        hitnum    = 3'($urandom);
        enable    = ($urandom_range(0, 15) != 0);
        reset     = ($urandom_range(0, 30) == 0);
      end
      cyc(1);
    end
    reset = 1'b0; enable = 1'b1; drive(16'h0000, DIR_IDLE);
    cyc(3);

    @(negedge clock); #1;
    req("queue_drained", q0.size() + q1.size(), 0);
    @(negedge clock); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
